// File: rtl/mini_core_rf_sb.sv
// Register-file scoreboard and issue controller for the mini-core Q101H stage.
// Tracks in-flight long-latency writes, stalls on RAW/WAW/capacity hazards, and watchdogs the stall.
module mini_core_rf_sb #(
  parameter int RF_NUM_MSB      = 31,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STALL_TIMEOUT   = 1023
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic                  IssueValidQ101H,
  input  logic [4:0]            RegSrc1Q101H,
  input  logic [4:0]            RegSrc2Q101H,
  input  logic                  Src1UsedQ101H,
  input  logic                  Src2UsedQ101H,
  input  logic [4:0]            RegDstQ101H,
  input  logic                  RegWrEnQ101H,
  input  logic                  LongLatQ101H,
  input  logic                  RetWrEnQ104H,
  input  logic [4:0]            RetDstQ104H,
  output logic                  ReadyQ102H,
  output logic [RF_NUM_MSB:0]   PendingVec,
  output logic [2:0]            OutstandingCnt,
  output logic [15:0]           StallCnt,
  output logic                  ErrTimeout,
  output logic                  ErrSpurRet,
  output logic [1:0]            DbgState
);

  localparam logic [5:0]  MSB      = 6'(RF_NUM_MSB);
  localparam logic [2:0]  MAX_CNT  = 3'(MAX_OUTSTANDING);
  localparam logic [15:0] TMO_LAST = 16'(STALL_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    ERR   = 2'd2
  } state_t;

  state_t state;

  logic [31:0]         pend_full;
  logic [31:0]         ret_mask;
  logic [31:0]         eff;
  logic [RF_NUM_MSB:0] pend_next;
  logic                ret;
  logic                ret_hit;
  logic                raw;
  logic                waw;
  logic                cap_full;
  logic                hazard;
  logic                dst_ok;
  logic                accept;

  // Zero-extend so any 5-bit index can be looked up; unimplemented registers read as not pending.
  always_comb begin
    pend_full = '0;
    for (int i = 0; i <= RF_NUM_MSB; i++) pend_full[i] = PendingVec[i];
  end

  // A same-cycle return is forwarded by the RF, so its register no longer counts as pending.
  assign ret      = RetWrEnQ104H && (RetDstQ104H != 5'd0) && ({1'b0, RetDstQ104H} <= MSB);
  assign ret_mask = ret ? (32'd1 << RetDstQ104H) : 32'd0;
  assign eff      = pend_full & ~ret_mask;
  assign ret_hit  = ret && pend_full[RetDstQ104H];

  assign raw      = (Src1UsedQ101H && eff[RegSrc1Q101H]) || (Src2UsedQ101H && eff[RegSrc2Q101H]);
  assign waw      = RegWrEnQ101H && eff[RegDstQ101H];
  assign cap_full = LongLatQ101H && RegWrEnQ101H && (OutstandingCnt == MAX_CNT) && !ret_hit;
  assign hazard   = IssueValidQ101H && (raw || waw || cap_full);

  assign ReadyQ102H = (state != ERR) && !hazard;
  assign dst_ok     = (RegDstQ101H != 5'd0) && ({1'b0, RegDstQ101H} <= MSB);
  assign accept     = IssueValidQ101H && ReadyQ102H && RegWrEnQ101H && LongLatQ101H && dst_ok;
  assign DbgState   = state;

  // A new load to the register being returned this cycle keeps it pending (set beats clear).
  always_comb begin
    pend_next = '0;
    for (int i = 0; i <= RF_NUM_MSB; i++)
      pend_next[i] = eff[i] || (accept && (RegDstQ101H == 5'(i)));
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state          <= RUN;
      PendingVec     <= '0;
      OutstandingCnt <= '0;
      StallCnt       <= '0;
      ErrTimeout     <= 1'b0;
      ErrSpurRet     <= 1'b0;
    end else begin
      PendingVec <= pend_next;

      if (accept && !ret_hit)      OutstandingCnt <= OutstandingCnt + 3'd1;
      else if (!accept && ret_hit) OutstandingCnt <= OutstandingCnt - 3'd1;

      if (ret && !ret_hit) ErrSpurRet <= 1'b1;

      if (!hazard)                  StallCnt <= '0;
      else if (StallCnt != 16'hFFFF) StallCnt <= StallCnt + 16'd1;

      case (state)
        RUN: begin
          if (hazard) state <= STALL;
        end
        STALL: begin
          if (!hazard) begin
            state <= RUN;
          end else if (StallCnt == TMO_LAST) begin
            state      <= ERR;
            ErrTimeout <= 1'b1;
          end
        end
        default: begin
          state      <= ERR;
          ErrTimeout <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mini_core_rf_sb.sv
// Bench for mini_core_rf_sb: directed hazard scenarios, watchdog, resets and a random mix,
// each cycle checked against a behavioural model through an expected-value queue.
module tb_mini_core_rf_sb;

  localparam int MSB  = 23;
  localparam int MAXO = 2;
  localparam int TMO  = 8;
  localparam int W    = 56;

  logic             Clock = 1'b0;
  logic             Rst;
  logic             IssueValidQ101H;
  logic [4:0]       RegSrc1Q101H;
  logic [4:0]       RegSrc2Q101H;
  logic             Src1UsedQ101H;
  logic             Src2UsedQ101H;
  logic [4:0]       RegDstQ101H;
  logic             RegWrEnQ101H;
  logic             LongLatQ101H;
  logic             RetWrEnQ104H;
  logic [4:0]       RetDstQ104H;
  logic             ReadyQ102H;
  logic [MSB:0]     PendingVec;
  logic [2:0]       OutstandingCnt;
  logic [15:0]      StallCnt;
  logic             ErrTimeout;
  logic             ErrSpurRet;
  logic [1:0]       DbgState;

  // clock / reset
  always #5 Clock = ~Clock;

  mini_core_rf_sb #(
    .RF_NUM_MSB(MSB), .MAX_OUTSTANDING(MAXO), .STALL_TIMEOUT(TMO)
  ) dut (
    .Clock(Clock), .Rst(Rst),
    .IssueValidQ101H(IssueValidQ101H),
    .RegSrc1Q101H(RegSrc1Q101H), .RegSrc2Q101H(RegSrc2Q101H),
    .Src1UsedQ101H(Src1UsedQ101H), .Src2UsedQ101H(Src2UsedQ101H),
    .RegDstQ101H(RegDstQ101H), .RegWrEnQ101H(RegWrEnQ101H), .LongLatQ101H(LongLatQ101H),
    .RetWrEnQ104H(RetWrEnQ104H), .RetDstQ104H(RetDstQ104H),
    .ReadyQ102H(ReadyQ102H), .PendingVec(PendingVec), .OutstandingCnt(OutstandingCnt),
    .StallCnt(StallCnt), .ErrTimeout(ErrTimeout), .ErrSpurRet(ErrSpurRet), .DbgState(DbgState)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [W-1:0] exp_q[$];
  logic        obs_ready;

  // behavioural model state
  logic [31:0] m_pend;
  int          m_cnt;
  int          m_state;
  int          m_stall;
  logic        m_spur;
  logic        m_errto;
  logic        m_ret;
  logic        m_hazard;
  logic        m_ready;
  logic        m_accept;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_eff(input logic [4:0] r);
    return (r != 5'd0) && (int'(r) <= MSB) && m_pend[r] && !(m_ret && RetDstQ104H == r);
  endfunction

  task automatic model_reset();
    m_pend = '0; m_cnt = 0; m_state = 0; m_stall = 0; m_spur = 1'b0; m_errto = 1'b0;
  endtask

  task automatic model_comb();
    logic raw, waw, cap;
    m_ret = RetWrEnQ104H && (RetDstQ104H != 5'd0) && (int'(RetDstQ104H) <= MSB);
    raw = (Src1UsedQ101H && m_eff(RegSrc1Q101H)) || (Src2UsedQ101H && m_eff(RegSrc2Q101H));
    waw = RegWrEnQ101H && m_eff(RegDstQ101H);
    cap = LongLatQ101H && RegWrEnQ101H && (m_cnt == MAXO) && !(m_ret && m_pend[RetDstQ104H]);
    m_hazard = IssueValidQ101H && (raw || waw || cap);
    m_ready  = (m_state != 2) && !m_hazard;
    m_accept = IssueValidQ101H && m_ready && RegWrEnQ101H && LongLatQ101H &&
               (RegDstQ101H != 5'd0) && (int'(RegDstQ101H) <= MSB);
  endtask

  task automatic model_seq();
    logic hit;
    hit = m_ret && m_pend[RetDstQ104H];
    if (m_ret && !hit) m_spur = 1'b1;
    if (hit) m_pend[RetDstQ104H] = 1'b0;
    if (m_accept) m_pend[RegDstQ101H] = 1'b1;
    if (m_accept && !hit) m_cnt++;
    else if (!m_accept && hit) m_cnt--;
    case (m_state)
      0: if (m_hazard) m_state = 1;
      1: if (!m_hazard) m_state = 0;
         else if (m_stall == TMO - 1) begin m_state = 2; m_errto = 1'b1; end
      default: m_state = 2;
    endcase
    m_stall = m_hazard ? ((m_stall == 65535) ? 65535 : m_stall + 1) : 0;
  endtask

  // scoreboard: push the model's view of this cycle, pop it once the DUT has settled
  task automatic push_exp();
    exp_q.push_back({m_ready, m_pend, 3'(m_cnt), 16'(m_stall), 2'(m_state), m_errto, m_spur});
  endtask

  task automatic check_outputs();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    obs_ready = ReadyQ102H;
    chk("ready",   {31'd0, ReadyQ102H},      {31'd0, e[55]});
    chk("pending", 32'(PendingVec),          e[54:23]);
    chk("outcnt",  {29'd0, OutstandingCnt},  {29'd0, e[22:20]});
    chk("stallcnt",{16'd0, StallCnt},        {16'd0, e[19:4]});
    chk("state",   {30'd0, DbgState},        {30'd0, e[3:2]});
    chk("errto",   {31'd0, ErrTimeout},      {31'd0, e[1]});
    chk("spurret", {31'd0, ErrSpurRet},      {31'd0, e[0]});
    chk("popcount", 32'($countones(PendingVec)), {29'd0, e[22:20]});
  endtask

  // driver tasks
  task automatic step(input logic iv, input logic [4:0] s1, input logic [4:0] s2,
                      input logic u1, input logic u2, input logic [4:0] dst,
                      input logic we, input logic ll, input logic rwe, input logic [4:0] rdst);
    @(negedge Clock);
    IssueValidQ101H = iv; RegSrc1Q101H = s1; RegSrc2Q101H = s2;
    Src1UsedQ101H = u1; Src2UsedQ101H = u2; RegDstQ101H = dst;
    RegWrEnQ101H = we; LongLatQ101H = ll; RetWrEnQ104H = rwe; RetDstQ104H = rdst;
    model_comb();
    push_exp();
    #1;
    check_outputs();
    model_seq();
  endtask

  task automatic ld(input logic [4:0] dst, input logic rwe, input logic [4:0] rdst);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, dst, 1'b1, 1'b1, rwe, rdst);
  endtask

  task automatic alu_rd(input logic [4:0] src, input logic rwe, input logic [4:0] rdst);
    step(1'b1, src, 5'd0, 1'b1, 1'b0, 5'd20, 1'b1, 1'b0, rwe, rdst);
  endtask

  task automatic idle(input logic rwe, input logic [4:0] rdst);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, rwe, rdst);
  endtask

  task automatic zero_inputs();
    IssueValidQ101H = 1'b0; RegSrc1Q101H = '0; RegSrc2Q101H = '0;
    Src1UsedQ101H = 1'b0; Src2UsedQ101H = 1'b0; RegDstQ101H = '0;
    RegWrEnQ101H = 1'b0; LongLatQ101H = 1'b0; RetWrEnQ104H = 1'b0; RetDstQ104H = '0;
  endtask

  // asynchronous reset asserted away from both clock edges
  task automatic do_reset();
    @(posedge Clock);
    #2;
    Rst = 1'b0;
    zero_inputs();
    model_reset();
    model_comb();
    push_exp();
    #1;
    check_outputs();
    chk("rst_ready", {31'd0, obs_ready}, 32'd1);
    @(negedge Clock);
    Rst = 1'b1;
  endtask

  initial begin
    zero_inputs();
    Rst = 1'b0;
    model_reset();
    model_comb();
    push_exp();
    #2;
    check_outputs();
    chk("rst_ready", {31'd0, obs_ready}, 32'd1);
    @(negedge Clock);
    Rst = 1'b1;

    // load x5 then dependent add; return arrives while stalled and is bypassed
    ld(5'd5, 1'b0, 5'd0);
    alu_rd(5'd5, 1'b0, 5'd0);
    chk("t1_stall", {31'd0, obs_ready}, 32'd0);
    chk("t1_pend5", {31'd0, PendingVec[5]}, 32'd1);
    chk("t1_cnt", {29'd0, OutstandingCnt}, 32'd1);
    alu_rd(5'd5, 1'b0, 5'd0);
    alu_rd(5'd5, 1'b1, 5'd5);
    chk("t1_bypass", {31'd0, obs_ready}, 32'd1);
    idle(1'b0, 5'd0);
    chk("t1_pend5_clr", {31'd0, PendingVec[5]}, 32'd0);

    // WAW on x7, then re-issue together with the return of x7
    ld(5'd7, 1'b0, 5'd0);
    ld(5'd7, 1'b0, 5'd0);
    chk("t2_waw_stall", {31'd0, obs_ready}, 32'd0);
    ld(5'd7, 1'b1, 5'd7);
    chk("t2_reissue", {31'd0, obs_ready}, 32'd1);
    idle(1'b0, 5'd0);
    chk("t2_pend7", {31'd0, PendingVec[7]}, 32'd1);
    chk("t2_cnt", {29'd0, OutstandingCnt}, 32'd1);
    idle(1'b1, 5'd7);

    // capacity limit of two outstanding loads
    ld(5'd1, 1'b0, 5'd0);
    ld(5'd2, 1'b0, 5'd0);
    ld(5'd3, 1'b0, 5'd0);
    chk("t3_capfull", {31'd0, obs_ready}, 32'd0);
    ld(5'd3, 1'b1, 5'd1);
    chk("t3_issue_on_ret", {31'd0, obs_ready}, 32'd1);
    idle(1'b0, 5'd0);
    chk("t3_cnt", {29'd0, OutstandingCnt}, 32'd2);
    idle(1'b1, 5'd2);
    idle(1'b1, 5'd3);

    // x0 never pending; out-of-range and spurious returns
    alu_rd(5'd0, 1'b0, 5'd0);
    chk("t4_x0_read", {31'd0, obs_ready}, 32'd1);
    ld(5'd0, 1'b0, 5'd0);
    chk("t4_x0_load", {31'd0, obs_ready}, 32'd1);
    ld(5'd30, 1'b1, 5'd30);
    idle(1'b1, 5'd9);
    chk("t4_nopend", 32'(PendingVec), 32'd0);
    idle(1'b0, 5'd0);
    chk("t4_spur", {31'd0, ErrSpurRet}, 32'd1);
    chk("t4_cnt", {29'd0, OutstandingCnt}, 32'd0);
    do_reset();

    // permanent RAW hazard drives the watchdog into the error state
    ld(5'd4, 1'b0, 5'd0);
    for (int i = 0; i < TMO + 2; i++) alu_rd(5'd4, 1'b0, 5'd0);
    chk("t5_errto", {31'd0, ErrTimeout}, 32'd1);
    chk("t5_ready_stuck", {31'd0, obs_ready}, 32'd0);
    idle(1'b1, 5'd4);
    chk("t5_err_idle_ready", {31'd0, obs_ready}, 32'd0);
    idle(1'b0, 5'd0);
    chk("t5_err_ret_cnt", {29'd0, OutstandingCnt}, 32'd0);
    do_reset();
    chk("t5_rst_errto", {31'd0, ErrTimeout}, 32'd0);

    // a return in flight across reset is spurious afterwards
    ld(5'd11, 1'b0, 5'd0);
    do_reset();
    idle(1'b1, 5'd11);
    idle(1'b0, 5'd0);
    chk("t5_spur_after_rst", {31'd0, ErrSpurRet}, 32'd1);
    do_reset();

    // random mix of issues and returns
    for (int i = 0; i < 1000; i++) begin
      logic       iv, u1, u2, we, ll, rwe, found;
      logic [4:0] s1, s2, dst, rdst;
      int         start;
      iv  = ($urandom_range(0, 3) != 0);
      s1  = 5'($urandom_range(0, 7) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 9));
      s2  = 5'($urandom_range(0, 9));
      u1  = 1'($urandom_range(0, 1));
      u2  = 1'($urandom_range(0, 1));
      dst = 5'($urandom_range(0, 7) == 0 ? $urandom_range(20, 31) : $urandom_range(0, 9));
      we  = ($urandom_range(0, 3) != 0);
      ll  = 1'($urandom_range(0, 1));
      rwe = ($urandom_range(0, 2) == 0);
      rdst = 5'($urandom_range(0, 31));
      if (rwe && m_pend != 0 && $urandom_range(0, 4) != 0) begin
        start = $urandom_range(0, 31);
        found = 1'b0;
        for (int k = 0; k < 32; k++) begin
          if (!found && m_pend[(start + k) % 32]) begin
            rdst  = 5'((start + k) % 32);
            found = 1'b1;
          end
        end
      end
      step(iv, s1, s2, u1, u2, dst, we, ll, rwe, rdst);
      if (m_state == 2) do_reset();
    end
    idle(1'b0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
